// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the wait-state SRAM controller state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_WAIT = 2'd1;
    localparam state_t S_ERR1 = 2'd2;
    localparam state_t S_ERR2 = 2'd3;

endpackage

// File: rtl/ahb_byte_strobe.sv
// Maps transfer size and low address bits to little-endian byte-lane strobes;
// flags sizes above a word and misaligned halfword/word transfers.
module ahb_byte_strobe
    import ahb_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] strb,
    output logic       illegal
);

    always_comb begin
        strb    = 4'b0000;
        illegal = 1'b0;
        case (size)
            HSIZE_BYTE: strb = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                if (addr_lo[0]) illegal = 1'b1;
                else            strb    = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            HSIZE_WORD: begin
                if (addr_lo != 2'b00) illegal = 1'b1;
                else                  strb    = 4'b1111;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_wait_sram.sv
// AHB-Lite subordinate in front of a 2**AW x 32 SRAM with a fixed wait-state count
// per OKAY transfer and a two-cycle ERROR response for illegal transfers.
//
//   state  | meaning
//   S_IDLE | ready; a legal data phase may be completing this cycle
//   S_WAIT | inserting wait states, counter runs down to zero
//   S_ERR1 | first ERROR cycle (HREADYOUT=0)
//   S_ERR2 | second ERROR cycle (HREADYOUT=1), may accept a new transfer
module ahb_wait_sram
    import ahb_pkg::*;
#(
    parameter int AW          = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_range
        $error("ahb_wait_sram: WAIT_STATES must be within 0..15");
    end

    localparam logic       HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0] WS_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            dp_valid_q, dp_valid_d;
    logic            write_q, write_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [3:0]      strb_q, strb_d;

    logic [31:0]     mem_q [2**AW];

    logic [3:0]      strb;
    logic            illegal;
    logic            accept;
    logic            complete;
    logic            mem_we;
    logic            unused_bits;

    assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

    ahb_byte_strobe u_strobe (
        .size    (HSIZE),
        .addr_lo (HADDR[1:0]),
        .strb    (strb),
        .illegal (illegal)
    );

    always_comb begin
        HREADYOUT = (state_q == S_IDLE) || (state_q == S_ERR2);
        HRESP     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    end

    assign accept   = HSEL & HTRANS[1] & HREADY & HREADYOUT;
    assign complete = dp_valid_q & HREADYOUT & HREADY;
    // A reset edge drops the in-flight write rather than letting it land.
    assign mem_we   = complete & write_q & HRESETn;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_ERR2: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (illegal) begin
                        state_d = S_ERR1;
                    end else if (HAS_WAIT) begin
                        state_d = S_WAIT;
                        cnt_d   = WS_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    // Data-phase context; an illegal transfer never becomes a pending SRAM access.
    always_comb begin
        dp_valid_d = dp_valid_q;
        write_d    = write_q;
        addr_d     = addr_q;
        strb_d     = strb_q;
        if (accept) begin
            dp_valid_d = ~illegal;
            write_d    = HWRITE;
            addr_d     = HADDR[AW+1:2];
            strb_d     = strb;
        end else if (complete) begin
            dp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            dp_valid_q <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            strb_q     <= 4'b0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dp_valid_q <= dp_valid_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            strb_q     <= strb_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_q[b]) mem_q[addr_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    // Asynchronous read so a write landing on the previous edge is already visible.
    assign HRDATA = (dp_valid_q && !write_q) ? mem_q[addr_q] : 32'h0;

endmodule

// File: tb/tb_ahb_wait_sram.sv
// Directed bench for ahb_wait_sram: one instance with one wait state and one with none,
// checked every cycle against a transfer-level model of the bus responses and memory.
module tb_ahb_wait_sram;
    import ahb_pkg::*;

    logic        hclk;
    logic        hresetn;
    logic [1:0]  hsel_v;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [1:0]  stall_v;
    logic [1:0]  hready_v;
    logic [1:0]  hreadyout_v;
    logic [1:0]  hresp_v;
    logic [31:0] hrdata0, hrdata1;

    // Bus-wide HREADY is this subordinate's ready unless another one is stalling.
    assign hready_v = hreadyout_v & ~stall_v;

    ahb_wait_sram #(.AW(10), .WAIT_STATES(1)) u_ws1 (
        .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel_v[0]), .HADDR(haddr), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready_v[0]),
        .HREADYOUT(hreadyout_v[0]), .HRESP(hresp_v[0]), .HRDATA(hrdata0)
    );

    ahb_wait_sram #(.AW(10), .WAIT_STATES(0)) u_ws0 (
        .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel_v[1]), .HADDR(haddr), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready_v[1]),
        .HREADYOUT(hreadyout_v[1]), .HRESP(hresp_v[1]), .HRDATA(hrdata1)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [31:0] rdata_of(input int i);
        return (i == 0) ? hrdata0 : hrdata1;
    endfunction

    // ---------------- transfer-level model ----------------
    // kind: 0 no data phase, 1 legal transfer, 2 error response; left = cycles remaining.
    logic [31:0] m_mem [2][1024];
    int          m_kind  [2] = '{0, 0};
    int          m_left  [2] = '{0, 0};
    int          m_word  [2];
    logic [31:0] m_mask  [2];
    bit          m_write [2];

    task automatic model_step(input int i);
        int ws;
        int sz;
        int a;
        bit legal;
        ws = (i == 0) ? 1 : 0;
        if (!hresetn) begin
            m_kind[i] = 0;
            m_left[i] = 0;
            return;
        end
        if (m_kind[i] != 0 && m_left[i] > 1) begin
            m_left[i]--;
            return;
        end
        if (m_kind[i] == 1) begin
            if (!hready_v[i]) return;
            if (m_write[i])
                m_mem[i][m_word[i]] = (m_mem[i][m_word[i]] & ~m_mask[i]) | (hwdata & m_mask[i]);
            m_kind[i] = 0;
        end else if (m_kind[i] == 2) begin
            m_kind[i] = 0;
        end
        if (hsel_v[i] && htrans[1] && hready_v[i]) begin
            sz    = int'(hsize);
            a     = int'(haddr[1:0]);
            legal = (sz == 0) || (sz == 1 && (a % 2) == 0) || (sz == 2 && a == 0);
            if (legal) begin
                m_kind[i]  = 1;
                m_left[i]  = ws + 1;
                m_word[i]  = int'(haddr[11:2]);
                m_write[i] = hwrite;
                m_mask[i]  = (sz == 0) ? (32'hFF << (8*a)) :
                             (sz == 1) ? (32'hFFFF << (8*a)) : 32'hFFFF_FFFF;
            end else begin
                m_kind[i] = 2;
                m_left[i] = 2;
            end
        end
    endtask

    always @(posedge hclk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    always @(negedge hclk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("u%0d_hreadyout", i), hreadyout_v[i],
                      (m_kind[i] == 0 || m_left[i] == 1) ? 1'b1 : 1'b0);
                check($sformatf("u%0d_hresp", i), hresp_v[i], (m_kind[i] == 2) ? 1'b1 : 1'b0);
                check($sformatf("u%0d_hrdata", i), rdata_of(i),
                      (m_kind[i] == 1 && !m_write[i]) ? m_mem[i][m_word[i]] : 32'h0);
            end
        end
    end

    // ---------------- pipelined bus driver ----------------
    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [31:0] wdata;
        logic [1:0]  trans;
        logic        sel;
    } xfer_t;

    xfer_t       q[$];
    logic [31:0] rd_log[$];
    int          lowcnt, errcnt, cycles;

    task automatic add(input logic [31:0] addr, input logic [2:0] size, input logic write,
                       input logic [31:0] wdata, input logic [1:0] trans = HTRANS_NONSEQ,
                       input logic sel = 1'b1);
        xfer_t x;
        x.addr = addr; x.size = size; x.write = write; x.wdata = wdata;
        x.trans = trans; x.sel = sel;
        q.push_back(x);
    endtask

    task automatic run(input int i);
        int    idx;
        bit    have_dp;
        bit    rdy;
        xfer_t dp;
        idx = 0; have_dp = 1'b0; cycles = 0; lowcnt = 0; errcnt = 0;
        dp = '{default: '0};
        rd_log.delete();
        while ((idx < q.size() || have_dp) && cycles < 200) begin
            @(negedge hclk);
            if (have_dp) hwdata = dp.wdata;
            hsel_v = 2'b00;
            if (idx < q.size()) begin
                hsel_v[i] = q[idx].sel;
                haddr     = q[idx].addr;
                hsize     = q[idx].size;
                hwrite    = q[idx].write;
                htrans    = q[idx].trans;
            end else begin
                htrans = HTRANS_IDLE;
            end
            #1;
            rdy = hready_v[i];
            if (!hreadyout_v[i]) lowcnt++;
            if (hresp_v[i]) errcnt++;
            if (have_dp && !dp.write && rdy) rd_log.push_back(rdata_of(i));
            @(posedge hclk);
            cycles++;
            if (rdy) begin
                have_dp = 1'b0;
                if (idx < q.size()) begin
                    have_dp = q[idx].sel && q[idx].trans[1];
                    dp      = q[idx];
                    idx++;
                end
            end
        end
        check($sformatf("u%0d_run_timeout", i), (cycles >= 200), 0);
        @(negedge hclk);
        hsel_v = 2'b00;
        htrans = HTRANS_IDLE;
        q.delete();
    endtask

    task automatic check_read(input string name, input int n, input logic [31:0] exp);
        check({name, "_count"}, rd_log.size(), n);
        if (rd_log.size() == n) check(name, rd_log[n-1], exp);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        hresetn = 1'b0; hsel_v = 2'b00; haddr = '0; htrans = HTRANS_IDLE;
        hsize = HSIZE_WORD; hwrite = 1'b0; hwdata = '0; stall_v = 2'b00;
        repeat (3) @(negedge hclk);
        chk_en  = 1'b1;
        hresetn = 1'b1;
        #1;
        check("reset_hreadyout", hreadyout_v, 2'b11);
        check("reset_hresp", hresp_v, 2'b00);
        check("reset_hrdata", hrdata0 | hrdata1, 32'h0);

        // Word write then read, one wait state each.
        add(32'h10, HSIZE_WORD, 1'b1, 32'hDEADBEEF);
        add(32'h10, HSIZE_WORD, 1'b0, 32'h0);
        run(0);
        check("ws1_low_cycles", lowcnt, 2);
        check_read("ws1_word_read", 1, 32'hDEADBEEF);

        // Byte write into lane 1 of an existing word.
        add(32'h20, HSIZE_WORD, 1'b1, 32'h11223344);
        add(32'h21, HSIZE_BYTE, 1'b1, 32'h0000AA00);
        add(32'h20, HSIZE_WORD, 1'b0, 32'h0);
        run(0);
        check_read("ws1_byte_merge", 1, 32'h1122AA44);

        // Half write to the upper half, then read back the merge.
        add(32'h22, HSIZE_HALF, 1'b1, 32'h5A5A0000);
        add(32'h20, HSIZE_WORD, 1'b0, 32'h0);
        run(0);
        check_read("ws1_half_merge", 1, 32'h5A5AAA44);

        // Illegal transfers: misaligned half, misaligned word, oversize.
        add(32'h00, HSIZE_WORD, 1'b1, 32'h55667788);
        add(32'h03, HSIZE_HALF, 1'b1, 32'hFFFFFFFF);
        add(32'h02, HSIZE_WORD, 1'b1, 32'hFFFFFFFF);
        add(32'h00, 3'b011,     1'b1, 32'hFFFFFFFF);
        add(32'h00, HSIZE_WORD, 1'b0, 32'h0);
        run(0);
        check("ws1_err_cycles", errcnt, 6);
        check_read("ws1_after_err", 1, 32'h55667788);

        // IDLE, BUSY and deselected transfers leave memory alone.
        add(32'h10, HSIZE_WORD, 1'b1, 32'h0, HTRANS_IDLE);
        add(32'h10, HSIZE_WORD, 1'b1, 32'h0, HTRANS_BUSY);
        add(32'h10, HSIZE_WORD, 1'b1, 32'h0, HTRANS_NONSEQ, 1'b0);
        add(32'h10, HSIZE_WORD, 1'b0, 32'h0);
        run(0);
        check_read("ws1_no_access", 1, 32'hDEADBEEF);

        // Another subordinate stalls HREADY: the presented write must not be taken.
        @(negedge hclk);
        stall_v = 2'b01; hsel_v = 2'b01; htrans = HTRANS_NONSEQ;
        hwrite = 1'b1; haddr = 32'h10; hsize = HSIZE_WORD; hwdata = 32'h01234567;
        repeat (2) @(negedge hclk);
        hsel_v = 2'b00; htrans = HTRANS_IDLE; stall_v = 2'b00;
        #1;
        check("stall_hreadyout", hreadyout_v[0], 1'b1);
        add(32'h10, HSIZE_WORD, 1'b0, 32'h0);
        run(0);
        check_read("ws1_after_stall", 1, 32'hDEADBEEF);

        // Zero wait states: back-to-back writes then reads at full rate.
        add(32'h0, HSIZE_WORD, 1'b1, 32'hA0A0A0A0);
        add(32'h4, HSIZE_WORD, 1'b1, 32'hB1B1B1B1);
        add(32'h8, HSIZE_WORD, 1'b1, 32'hC2C2C2C2);
        add(32'hC, HSIZE_WORD, 1'b1, 32'hD3D3D3D3);
        add(32'h0, HSIZE_WORD, 1'b0, 32'h0);
        add(32'h4, HSIZE_WORD, 1'b0, 32'h0);
        add(32'h8, HSIZE_WORD, 1'b0, 32'h0);
        add(32'hC, HSIZE_WORD, 1'b0, 32'h0);
        run(1);
        check("ws0_cycles", cycles, 9);
        check("ws0_low_cycles", lowcnt, 0);
        check("ws0_read_count", rd_log.size(), 4);
        if (rd_log.size() == 4) begin
            check("ws0_read0", rd_log[0], 32'hA0A0A0A0);
            check("ws0_read1", rd_log[1], 32'hB1B1B1B1);
            check("ws0_read2", rd_log[2], 32'hC2C2C2C2);
            check("ws0_read3", rd_log[3], 32'hD3D3D3D3);
        end

        // Zero wait states: write immediately followed by read of the same word.
        add(32'h40, HSIZE_WORD, 1'b1, 32'h13579BDF);
        add(32'h40, HSIZE_WORD, 1'b0, 32'h0);
        run(1);
        check_read("ws0_wr_rd_same", 1, 32'h13579BDF);

        // Reset during the wait state of a write: the write must be dropped.
        add(32'h30, HSIZE_WORD, 1'b1, 32'h0BADF00D);
        run(0);
        hsel_v = 2'b01; htrans = HTRANS_NONSEQ; hwrite = 1'b1;
        haddr = 32'h30; hsize = HSIZE_WORD;
        @(negedge hclk);
        hsel_v = 2'b00; htrans = HTRANS_IDLE; hwdata = 32'hFFFFFFFF;
        #1;
        check("wait_before_reset", hreadyout_v[0], 1'b0);
        hresetn = 1'b0;
        @(negedge hclk);
        hresetn = 1'b1;
        #1;
        check("post_reset_hreadyout", hreadyout_v[0], 1'b1);
        check("post_reset_hresp", hresp_v[0], 1'b0);
        check("post_reset_hrdata", hrdata0, 32'h0);
        add(32'h30, HSIZE_WORD, 1'b0, 32'h0);
        run(0);
        check_read("ws1_reset_dropped_write", 1, 32'h0BADF00D);

        repeat (2) @(negedge hclk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
